// File: rtl/obstacle_scroller.sv
// Obstacle position generator: per-frame scroll, LFSR-based respawn height, pass pulse.
// Optional per-level speed-up is enabled by defining OBSTACLE_SPEEDUP_EN.
module obstacle_scroller #(
    parameter int SCREEN_W         = 640,
    parameter int OBSTACLE_WIDTH   = 100,
    parameter int Y_MIN            = 40,
    parameter int Y_MAX            = 400,
    parameter int PLAYER_X         = 160,
    parameter int SPEED_INIT       = 2,
    parameter int SPEED_MAX        = 8,
    parameter int PASSES_PER_LEVEL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collision,
    output logic [10:0] pipe_x,
    output logic [9:0]  pipe_y,
    output logic [3:0]  speed,
    output logic        passed,
    output logic        running
);
    // state | meaning
    // IDLE  | after reset, waiting for start
    // RUN   | scrolling on frame_tick
    // HALT  | frozen after collision, waiting for start
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [9:0]  RANGE_L  = 10'(Y_MAX - Y_MIN + 1);
    localparam logic [9:0]  Y_MIN_L  = 10'(Y_MIN);
    localparam logic [10:0] SCREEN_L = 11'(SCREEN_W);
    localparam logic [11:0] OW_L     = 12'(OBSTACLE_WIDTH);
    localparam logic [11:0] PX_L     = 12'(PLAYER_X);
    localparam logic [3:0]  SPD_INIT = 4'(SPEED_INIT);

    state_t      state, state_nxt;
    logic [9:0]  lfsr;
    logic [9:0]  fold_1, fold_2, y_rand;
    logic        do_init, do_move, do_wrap, pass_hit;
    logic [10:0] x_sub;
    logic [11:0] old_sum, new_sum;
    logic [10:0] x_nxt;
    logic [9:0]  y_nxt;
    logic [3:0]  speed_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (collision) state_nxt = HALT;
            HALT:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // x^10 + x^7 + 1; runs in every state so respawn heights differ between games
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 10'h3FF;
        else        lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end

    always_comb begin
        fold_1 = (lfsr >= RANGE_L) ? lfsr - RANGE_L : lfsr;
        fold_2 = (fold_1 >= RANGE_L) ? fold_1 - RANGE_L : fold_1;
        y_rand = Y_MIN_L + fold_2;
    end

    always_comb begin
        do_init  = (state != RUN) && start;
        do_move  = (state == RUN) && !collision && frame_tick;
        do_wrap  = do_move && (pipe_x < {7'b0, speed});
        x_sub    = pipe_x - {7'b0, speed};
        old_sum  = {1'b0, pipe_x} + OW_L;
        new_sum  = {1'b0, x_sub} + OW_L;
        pass_hit = do_move && !do_wrap && (old_sum >= PX_L) && (new_sum < PX_L);
        x_nxt    = pipe_x;
        y_nxt    = pipe_y;
        if (do_init || do_wrap) begin
            x_nxt = SCREEN_L;
            y_nxt = y_rand;
        end else if (do_move) begin
            x_nxt = x_sub;
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    logic [7:0] pass_cnt, pass_cnt_nxt, pass_cnt_inc;

    always_comb begin
        pass_cnt_inc = pass_cnt + 8'd1;
        pass_cnt_nxt = pass_cnt;
        speed_nxt    = speed;
        if (do_init) begin
            pass_cnt_nxt = 8'd0;
            speed_nxt    = SPD_INIT;
        end else if (pass_hit) begin
            if (pass_cnt_inc == 8'(PASSES_PER_LEVEL)) begin
                pass_cnt_nxt = 8'd0;
                if (speed < 4'(SPEED_MAX)) speed_nxt = speed + 4'd1;
            end else begin
                pass_cnt_nxt = pass_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pass_cnt <= 8'd0;
        else        pass_cnt <= pass_cnt_nxt;
    end
`else
    always_comb begin
        speed_nxt = do_init ? SPD_INIT : speed;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_x  <= SCREEN_L;
            pipe_y  <= Y_MIN_L;
            speed   <= SPD_INIT;
            passed  <= 1'b0;
            running <= 1'b0;
        end else begin
            pipe_x  <= x_nxt;
            pipe_y  <= y_nxt;
            speed   <= speed_nxt;
            passed  <= pass_hit;
            running <= (state_nxt == RUN);
        end
    end
endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: driver pushes expected outputs, monitors pop and compare.
module tb_obstacle_scroller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        collision = 1'b0;
    logic [10:0] pipe_x;
    logic [9:0]  pipe_y;
    logic [3:0]  speed;
    logic        passed;
    logic        running;

    obstacle_scroller dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .collision(collision), .pipe_x(pipe_x), .pipe_y(pipe_y), .speed(speed),
        .passed(passed), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [3:0]  spd;
        logic        pas;
        logic        run;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         m_state = 0;  // 0 idle, 1 run, 2 halt
    int         m_x = 640, m_y = 40, m_spd = 2, m_cnt = 0;
    logic [9:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 10'h3FF;
        else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic int fold(input logic [9:0] v);
        int r = int'(v);
        if (r >= 361) r -= 361;
        if (r >= 361) r -= 361;
        return r;
    endfunction

    task automatic compare(input exp_t e);
        n_vec++;
        if (pipe_x !== e.x || pipe_y !== e.y || speed !== e.spd ||
            passed !== e.pas || running !== e.run) begin
            n_err++;
            $display("FAIL vec%0d @%0t: got x=%0d y=%0d spd=%0d passed=%0b run=%0b, want x=%0d y=%0d spd=%0d passed=%0b run=%0b",
                     n_vec, $time, pipe_x, pipe_y, speed, passed, running,
                     e.x, e.y, e.spd, e.pas, e.run);
        end
        if (pipe_y < 10'd40 || pipe_y > 10'd400) begin
            n_err++;
            $display("FAIL y_range @%0t: got y=%0d, want 40..400", $time, pipe_y);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) compare(q.pop_front());
    end

    always @(negedge rst_n) begin
        #1;
        if (q.size() > 0) compare(q.pop_front());
    end

    task automatic push_model(input bit pas);
        exp_t e;
        e.x   = 11'(m_x);
        e.y   = 10'(m_y);
        e.spd = 4'(m_spd);
        e.pas = pas;
        e.run = (m_state == 1);
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 640; m_y = 40; m_spd = 2; m_cnt = 0;
    endtask

    task automatic cycle(input bit ft, input bit st, input bit col);
        int nx;
        bit pas;
        @(negedge clk);
        rst_n = 1'b1; frame_tick = ft; start = st; collision = col;
        pas = 1'b0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_x = 640; m_y = 40 + fold(m_lfsr); m_spd = 2; m_cnt = 0;
            end
        end else if (col) begin
            m_state = 2;
        end else if (ft) begin
            if (m_x < m_spd) begin
                m_x = 640; m_y = 40 + fold(m_lfsr);
            end else begin
                nx  = m_x - m_spd;
                pas = (m_x + 100 >= 160) && (nx + 100 < 160);
                m_x = nx;
`ifdef OBSTACLE_SPEEDUP_EN
                if (pas) begin
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_cnt = 0;
                        if (m_spd < 8) m_spd++;
                    end
                end
`endif
            end
        end
        push_model(pas);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        frame_tick = 1'b1; start = 1'b0; collision = 1'b0;
        model_reset();
        push_model(1'b0);
        rst_n = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        model_reset();
        push_model(1'b0);
        rst_n = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2000 && m_x != target; i++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_cycle();
        rst_cycle();
        cycle(1'b1, 1'b0, 1'b0);          // tick in IDLE ignored
        cycle(1'b0, 1'b0, 1'b1);          // collision in IDLE ignored
        cycle(1'b1, 1'b1, 1'b0);          // start; same-cycle tick ignored
        cycle(1'b1, 1'b0, 1'b0);          // 640 -> 638
        cycle(1'b1, 1'b1, 1'b0);          // start in RUN ignored
        run_to(300);
        cycle(1'b1, 1'b0, 1'b1);          // collision wins over tick
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);          // restart from HALT
        run_to(200);
        async_reset();
        rst_cycle();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run_to(60);
        cycle(1'b1, 1'b0, 1'b0);          // 60 -> 58 passes the player
        cycle(1'b1, 1'b0, 1'b0);          // 58 -> 56 no pulse
        run_to(0);
        cycle(1'b1, 1'b0, 1'b0);          // wrap, no pulse
        for (int i = 0; i < 8000; i++)
            cycle((i % 7) != 3, (i % 500) == 17, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
